// File: rtl/keypad_scan_if.sv
// Keypad scanner signal bundle: scan strobe, matrix row/col lines and key event outputs.
// Latency: none; this is a pure connection bundle.
// Backpressure: none; key events are single-cycle pulses with no ready path.
interface keypad_scan_if;
    logic       enable;     // scan-step strobe, one clk wide
    logic [3:0] row;        // keypad rows, active-low, asynchronous
    logic [3:0] col;        // column drive, active-low one-hot
    logic [3:0] key_code;   // last accepted key, row_idx*4 + col_idx
    logic       key_valid;  // one-clk pulse per accepted press
    logic       key_down;   // high while an accepted key is held

    // Environment side: owns the strobe and the physical rows.
    modport master (
        output enable,
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_down
    );

    // Scanner side.
    modport slave (
        input  enable,
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_down
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with debounce; one key event per physical press.
// Latency: 2 clk row synchroniser, then DEBOUNCE_TICKS+1 enable strobes from capture to key_valid.
// Backpressure: none; key_valid is a one-clk pulse and must be consumed when it appears.
module keypad_scan #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.slave  kp
);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    localparam logic [3:0] DB_LIM = 4'(DEBOUNCE_TICKS);

    // Position of the single low bit in an active-low row pattern.
    function automatic logic [1:0] row_enc(input logic [3:0] pat);
        logic [1:0] idx;
        idx = 2'd0;
        case (pat)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Synchroniser stages
    logic [3:0] row_s1_q, row_s1_d;
    logic [3:0] row_s_q,  row_s_d;

    // Scan / debounce state
    state_t     state_q,     state_d;
    logic [1:0] col_idx_q,   col_idx_d;
    logic [1:0] cidx_q,      cidx_d;
    logic [3:0] pat_q,       pat_d;
    logic [3:0] cnt_q,       cnt_d;

    // Outputs
    logic [3:0] key_code_q,  key_code_d;
    logic       key_valid_q, key_valid_d;
    logic       key_down_q,  key_down_d;

    // Decoded views of the synchronised rows
    logic [3:0] row_n;
    logic       rows_idle;
    logic       single_key;
    logic [3:0] cnt_inc;

    // Two-flop synchroniser input staging; runs every clk regardless of enable.
    always_comb begin
        row_s1_d = kp.row;
        row_s_d  = row_s1_q;
    end

    // Synchroniser registers; reset to "no key" so no phantom press follows reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1_q <= 4'hF;
            row_s_q  <= 4'hF;
        end else begin
            row_s1_q <= row_s1_d;
            row_s_q  <= row_s_d;
        end
    end

    // Row pattern classification: idle, exactly one key, or ghost/multi-key.
    always_comb begin
        row_n      = ~row_s_q;
        rows_idle  = (row_s_q == 4'hF);
        single_key = (row_n != 4'h0) && ((row_n & (row_n - 4'd1)) == 4'h0);
        cnt_inc    = cnt_q + 4'd1;
    end

    // Next-state and output logic; nothing but key_valid's self-clear moves without enable.
    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        cidx_d      = cidx_q;
        pat_d       = pat_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_down_d  = key_down_q;
        key_valid_d = 1'b0;

        if (kp.enable) begin
            case (state_q)
                SCAN: begin
                    if (single_key) begin
                        // Freeze the column on the candidate and start counting.
                        pat_d   = row_s_q;
                        cidx_d  = col_idx_q;
                        cnt_d   = 4'd0;
                        state_d = DEBOUNCE;
                    end else begin
                        // Nothing or an ambiguous pattern: move on to the next column.
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end

                DEBOUNCE: begin
                    if (row_s_q == pat_q) begin
                        if (cnt_inc == DB_LIM) begin
                            key_code_d  = {row_enc(pat_q), cidx_q};
                            key_valid_d = 1'b1;
                            key_down_d  = 1'b1;
                            cnt_d       = 4'd0;
                            state_d     = HELD;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // Bounce: abandon the candidate and resume scanning.
                        cnt_d     = 4'd0;
                        state_d   = SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end

                HELD: begin
                    if (rows_idle) begin
                        if (cnt_inc == DB_LIM) begin
                            key_down_d = 1'b0;
                            cnt_d      = 4'd0;
                            state_d    = SCAN;
                            col_idx_d  = cidx_q + 2'd1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // Still pressed, bouncing or a second key: restart the release count.
                        cnt_d = 4'd0;
                    end
                end

                default: begin
                    state_d = SCAN;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCAN;
            col_idx_q   <= 2'd0;
            cidx_q      <= 2'd0;
            pat_q       <= 4'hF;
            cnt_q       <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            cidx_q      <= cidx_d;
            pat_q       <= pat_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    // Column drive follows col_idx directly; event outputs are masked while rst is high.
    always_comb begin
        kp.col       = ~(4'b0001 << col_idx_q);
        kp.key_code  = key_code_q;
        kp.key_valid = key_valid_q & ~rst;
        kp.key_down  = key_down_q & ~rst;
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a matrix keypad model and key-event scoreboard.
// Latency: each strobe step is 3 idle clk then one enable clk, so rows settle before sampling.
// Backpressure: none; every key_valid pulse is popped and compared immediately.
module tb_keypad_scan;

    logic clk;
    logic rst;
    logic [15:0] pressed;   // pressed[r*4+c] = key (r,c) held down
    logic [3:0]  row_m;

    int total;
    int bad;
    int valid_cnt;
    logic kv_prev;
    logic [3:0] exp_q[$];

    keypad_scan_if kif();

    keypad_scan #(.DEBOUNCE_TICKS(4)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad model: row r pulled low when a pressed key in row r sits on a driven column.
    always_comb begin
        row_m = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !kif.col[c]) row_m[r] = 1'b0;
            end
        end
    end
    assign kif.row = row_m;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One scan step: settle time, then a single-clk enable strobe; returns at the next negedge.
    task automatic strobe(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (3) @(negedge clk);
            kif.enable = 1'b1;
            @(negedge clk);
            kif.enable = 1'b0;
        end
    endtask

    // Scoreboard: each key_valid pulse must be one clk wide and match the oldest expected code.
    initial kv_prev = 1'b0;
    always @(negedge clk) begin
        if (kif.key_valid === 1'b1) begin
            valid_cnt++;
            check("kv_width", {7'd0, kv_prev}, 8'd0);
            if (exp_q.size() == 0)
                check("kv_unexpected", {7'd0, kif.key_valid}, 8'd0);
            else
                check("kv_code", {4'd0, kif.key_code}, {4'd0, exp_q.pop_front()});
        end
        kv_prev = kif.key_valid;
    end

    initial begin
        logic [3:0] col_b;
        int v0;
        total     = 0;
        bad       = 0;
        valid_cnt = 0;
        rst        = 1'b1;
        kif.enable = 1'b0;
        pressed    = 16'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_col",  {4'd0, kif.col}, 8'h0E);
        check("rst_code", {4'd0, kif.key_code}, 8'h00);
        check("rst_kv",   {7'd0, kif.key_valid}, 8'h00);
        check("rst_kd",   {7'd0, kif.key_down}, 8'h00);
        rst = 1'b0;

        // Idle scan: one column step per enable
        strobe(1); check("idle_col1", {4'd0, kif.col}, 8'h0D);
        strobe(1); check("idle_col2", {4'd0, kif.col}, 8'h0B);
        strobe(1); check("idle_col3", {4'd0, kif.col}, 8'h07);
        strobe(1); check("idle_col0", {4'd0, kif.col}, 8'h0E);
        check("idle_kd", {7'd0, kif.key_down}, 8'h00);
        check("idle_vcnt", valid_cnt[7:0], 8'd0);

        // Press (2,1): col0 pass, capture at col1, then 4 matches
        pressed[9] = 1'b1;
        exp_q.push_back(4'h9);
        strobe(5);
        check("p21_kd_early", {7'd0, kif.key_down}, 8'h00);
        strobe(1);
        check("p21_kd",   {7'd0, kif.key_down}, 8'h01);
        check("p21_code", {4'd0, kif.key_code}, 8'h09);
        strobe(14);
        check("p21_col_frozen", {4'd0, kif.col}, 8'h0D);
        check("p21_vcnt", valid_cnt[7:0], 8'd1);
        pressed[9] = 1'b0;
        strobe(3);
        check("p21_rel_early", {7'd0, kif.key_down}, 8'h01);
        strobe(1);
        check("p21_rel_kd",  {7'd0, kif.key_down}, 8'h00);
        check("p21_rel_col", {4'd0, kif.col}, 8'h0B);

        // Bounce on (0,3): never stable for 4 samples
        v0 = valid_cnt;
        for (int k = 0; k < 3; k++) begin
            pressed[3] = 1'b1;
            strobe(2);
            pressed[3] = 1'b0;
            strobe(2);
        end
        check("bnc_vcnt", valid_cnt[7:0], v0[7:0]);
        check("bnc_code", {4'd0, kif.key_code}, 8'h09);
        check("bnc_kd",   {7'd0, kif.key_down}, 8'h00);
        col_b = kif.col;
        strobe(1);
        check("bnc_scan", {4'd0, kif.col}, {4'd0, col_b[2:0], col_b[3]});

        // Ghost: (1,0)+(3,0) on one column is rejected
        v0 = valid_cnt;
        pressed[4]  = 1'b1;
        pressed[12] = 1'b1;
        strobe(12);
        check("ghost_vcnt", valid_cnt[7:0], v0[7:0]);
        check("ghost_kd",   {7'd0, kif.key_down}, 8'h00);
        pressed[12] = 1'b0;
        exp_q.push_back(4'h4);
        strobe(12);
        check("ghost_code", {4'd0, kif.key_code}, 8'h04);
        check("ghost_kd2",  {7'd0, kif.key_down}, 8'h01);
        pressed[4] = 1'b0;
        strobe(6);
        check("ghost_rel", {7'd0, kif.key_down}, 8'h00);

        // Overlap: (3,3) held, (0,0) added, both released, (0,0) pressed again
        v0 = valid_cnt;
        pressed[15] = 1'b1;
        exp_q.push_back(4'hF);
        strobe(12);
        check("ovl_codeF", {4'd0, kif.key_code}, 8'h0F);
        pressed[0] = 1'b1;
        strobe(8);
        check("ovl_code_hold", {4'd0, kif.key_code}, 8'h0F);
        check("ovl_vcnt1", valid_cnt[7:0], 8'(v0 + 1));
        pressed[0]  = 1'b0;
        pressed[15] = 1'b0;
        strobe(6);
        check("ovl_rel", {7'd0, kif.key_down}, 8'h00);
        pressed[0] = 1'b1;
        exp_q.push_back(4'h0);
        strobe(12);
        check("ovl_code0", {4'd0, kif.key_code}, 8'h00);
        check("ovl_vcnt2", valid_cnt[7:0], 8'(v0 + 2));
        pressed[0] = 1'b0;
        strobe(6);

        // Reset while HELD on (1,1)
        pressed[5] = 1'b1;
        exp_q.push_back(4'h5);
        strobe(12);
        check("rh_kd", {7'd0, kif.key_down}, 8'h01);
        v0 = valid_cnt;
        rst = 1'b1;
        #1;
        check("rh_kd_in_rst", {7'd0, kif.key_down}, 8'h00);
        @(negedge clk);
        check("rh_col",  {4'd0, kif.col}, 8'h0E);
        check("rh_code", {4'd0, kif.key_code}, 8'h00);
        check("rh_kd2",  {7'd0, kif.key_down}, 8'h00);
        pressed[5] = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Reset at DEBOUNCE cnt=3 on (1,2): two empty columns, capture, three matches
        pressed[6] = 1'b1;
        strobe(6);
        rst = 1'b1;
        @(negedge clk);
        check("rd_col",  {4'd0, kif.col}, 8'h0E);
        check("rd_code", {4'd0, kif.key_code}, 8'h00);
        check("rd_kd",   {7'd0, kif.key_down}, 8'h00);
        pressed[6] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        strobe(6);
        check("rd_vcnt", valid_cnt[7:0], v0[7:0]);
        check("sb_empty", exp_q.size() == 0 ? 8'd0 : 8'd1, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4x4 matrix keypad: drives one column low at a time and reads the active-low rows.
- Debounces the key, then reports one encoded press event per physical press.
- Input-side counterpart of the multiplexed display scanner; shares its scan-step strobe (enable) and feeds the clock/calendar time-set logic.

Parameters:
DEBOUNCE_TICKS, 4, consecutive matching enable samples required to accept a press or a release (legal range 1..15)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
enable  input  1  scan-step strobe, one clk wide; period guaranteed >= 4 clk
row  input  4  keypad rows, active-low, externally pulled up, asynchronous
col  output  4  keypad column drive, active-low one-hot
key_code  output  4  last accepted key, row_idx*4 + col_idx
key_valid  output  1  one-clk pulse when a press is accepted
key_down  output  1  high from press acceptance until release acceptance

Behaviour:
- Reset (synchronous, rst sampled high at a clk edge):
  - col=4'b1110, key_code=0, key_valid=0, key_down=0.
  - state=SCAN, col_idx=0, all counters 0, synchroniser flops=4'hF.
- row passes through a 2-flop synchroniser (row_s); every decision below uses row_s.
- All state changes occur only on clk edges where enable=1. With enable=0, everything except the synchroniser holds, and key_valid is 0.
- col = ~(4'b0001 << col_idx) at all times. It changes only when col_idx advances.
- "Single key" means row_s has exactly one zero bit; its position is row_idx.
- SCAN:
  - row_s==4'hF, or more than one zero (ghost/multi-key): col_idx <= col_idx+1, wrapping 3->0. Stay in SCAN.
  - Single key: capture pat<=row_s and cidx<=col_idx, cnt<=0, go to DEBOUNCE. col holds.
- DEBOUNCE:
  - row_s==pat: cnt<=cnt+1.
    - If cnt+1==DEBOUNCE_TICKS: key_code<=row_idx*4+cidx, key_valid<=1 for the following clk only, key_down<=1, cnt<=0, go to HELD.
  - row_s!=pat: return to SCAN, advance col_idx. No key_valid.
- HELD (col held on cidx):
  - row_s==4'hF: cnt<=cnt+1.
    - If cnt+1==DEBOUNCE_TICKS: key_down<=0, go to SCAN, advance col_idx.
  - Any other value (still pressed, bounce, or second key): cnt<=0. No autorepeat, no new key_valid.
- Press latency: key_valid rises on the clk after the enable edge that completes the count. Minimum is DEBOUNCE_TICKS+1 enable strobes after the capture strobe, plus 2 clk synchroniser delay before capture.
- key_code holds its value until the next accepted press. It is never cleared except by rst.
- key_valid and key_down never assert in the same cycle as rst=1.
- A second key pressed while in HELD is ignored. It can only be accepted after the first key's release has been accepted.
- Reset mid-DEBOUNCE or mid-HELD: the next cycle shows reset values. No key_valid is emitted.
- Counter width: 4 bits, sufficient for DEBOUNCE_TICKS<=15.

Test Plan:
- Bench keypad model for all scenarios: row[r]=0 iff key (r,c) is pressed and col[c]==0.
- rst high 3 clk, then idle with enable every 4 clk -> col sequence 1110,1101,1011,0111,1110 (one step per enable); key_valid=0, key_down=0, key_code=0.
- Press key (row2,col1) and hold for 20 enables, DEBOUNCE_TICKS=4 -> exactly one key_valid pulse, 1 clk wide; key_code=4'h9; key_down=1; col frozen at 1101. Release -> key_down falls after 4 all-high enable samples, then scanning resumes at 1011.
- Bounce: press (row0,col3) for 2 enables, release, repeat 3 times -> no key_valid, key_code unchanged, scanning continues.
- Ghost: press (row1,col0) and (row3,col0) together -> column 0 rejected every pass, no key_valid. Releasing row3 leaves a single key -> key_valid with key_code=4'h4.
- While holding (row3,col3) (code 4'hF), press (row0,col0), release both, press (row0,col0) again -> first press gives key_valid with 4'hF. The overlapping (row0,col0) press gives none. Only after 4'hF's release is accepted does the later (row0,col0) press give key_valid with key_code=4'h0.
- Assert rst during HELD, and separately at DEBOUNCE cnt=3 -> next clk: col=1110, key_down=0, key_code=0, no key_valid pulse.
